// File: rtl/mem_dump_tx.sv
// Boot-RAM readback engine: reads a block of 32-bit words and streams them LSB byte first over UART 8N1.
// Optional DUMP_CHECKSUM_EN appends one XOR-of-all-data-bytes byte before DONE.
module mem_dump_tx #(
   parameter int ADDR_WIDTH  = 12,
   parameter int COUNTER_MSB = 9
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [COUNTER_MSB-1:0] halfPeriod,
   input  logic                   start,
   input  logic [ADDR_WIDTH-1:0]  startAddr,
   input  logic [ADDR_WIDTH:0]    wordCount,
   output logic [ADDR_WIDTH-1:0]  memAddr,
   output logic                   memEn,
   input  logic [31:0]            memData,
   output logic                   TX,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_SEND, S_DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
   localparam logic [ADDR_WIDTH:0]   REM_ONE  = 1;
   localparam logic [COUNTER_MSB:0]  CNT_ONE  = 1;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d, mem_addr_q;
   logic [ADDR_WIDTH:0]     rem_q, rem_d;
   logic [31:0]             shift_q, shift_d;
   logic [3:0]              bit_q, bit_d;
   logic [1:0]              byte_q, byte_d;
   logic [COUNTER_MSB:0]    cnt_q, cnt_d;
   logic                    tx_q, tx_d, mem_en_q, busy_q, done_q;
   logic [COUNTER_MSB:0]    bit_last;
`ifdef DUMP_CHECKSUM_EN
   logic [7:0]              csum_q, csum_d;
   logic                    csum_ph_q, csum_ph_d;
`endif

   // Last count of a bit period: 2*(halfPeriod+1)-1.
   assign bit_last = {halfPeriod, 1'b1};

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      cnt_d   = cnt_q;
      tx_d    = 1'b1;
`ifdef DUMP_CHECKSUM_EN
      csum_d    = csum_q;
      csum_ph_d = csum_ph_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d = startAddr;
               rem_d  = wordCount;
               cnt_d  = '0;
               bit_d  = '0;
               byte_d = '0;
`ifdef DUMP_CHECKSUM_EN
               csum_d    = '0;
               csum_ph_d = 1'b0;
               if (wordCount == '0) begin
                  shift_d   = '0;
                  csum_ph_d = 1'b1;
                  state_d   = S_SEND;
               end else begin
                  state_d = S_FETCH;
               end
`else
               state_d = (wordCount == '0) ? S_DONE : S_FETCH;
`endif
            end
         end
         S_FETCH: state_d = S_LATCH;
         S_LATCH: begin
            shift_d = memData;
            byte_d  = '0;
            bit_d   = '0;
            cnt_d   = '0;
            state_d = S_SEND;
`ifdef DUMP_CHECKSUM_EN
            csum_d = csum_q ^ memData[7:0] ^ memData[15:8] ^ memData[23:16] ^ memData[31:24];
`endif
         end
         S_SEND: begin
            if (cnt_q == bit_last) begin
               cnt_d = '0;
               // bit 0 = start, 1..8 = data, 9 = stop
               if (bit_q == 4'd9) begin
                  bit_d   = '0;
                  byte_d  = byte_q + 2'd1;
                  shift_d = {8'h00, shift_q[31:8]};
`ifdef DUMP_CHECKSUM_EN
                  if (csum_ph_q) state_d = S_DONE;
                  else
`endif
                  if (byte_q == 2'd3) begin
                     addr_d = addr_q + ADDR_ONE;
                     rem_d  = rem_q - REM_ONE;
                     if (rem_q == REM_ONE) begin
`ifdef DUMP_CHECKSUM_EN
                        shift_d   = {24'h0, csum_q};
                        byte_d    = '0;
                        csum_ph_d = 1'b1;
`else
                        state_d = S_DONE;
`endif
                     end else begin
                        state_d = S_FETCH;
                     end
                  end
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // TX is registered from next-state values so the pin never glitches.
      if (state_d == S_SEND) begin
         case (bit_d)
            4'd0:    tx_d = 1'b0;
            4'd9:    tx_d = 1'b1;
            default: tx_d = shift_d[3'(bit_d - 4'd1)];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         mem_addr_q <= '0;
         rem_q      <= '0;
         shift_q    <= '0;
         bit_q      <= '0;
         byte_q     <= '0;
         cnt_q      <= '0;
         tx_q       <= 1'b1;
         mem_en_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
         csum_q     <= '0;
         csum_ph_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         rem_q    <= rem_d;
         shift_q  <= shift_d;
         bit_q    <= bit_d;
         byte_q   <= byte_d;
         cnt_q    <= cnt_d;
         tx_q     <= tx_d;
         mem_en_q <= (state_d == S_FETCH);
         busy_q   <= (state_d == S_FETCH) || (state_d == S_LATCH) || (state_d == S_SEND);
         done_q   <= (state_d == S_DONE);
         if (state_d == S_FETCH) mem_addr_q <= addr_d;
`ifdef DUMP_CHECKSUM_EN
         csum_q    <= csum_d;
         csum_ph_q <= csum_ph_d;
`endif
      end
   end

   assign memAddr = mem_addr_q;
   assign memEn   = mem_en_q;
   assign TX      = tx_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_mem_dump_tx.sv
// Scoreboard bench for mem_dump_tx: expected reads/bytes queued at start, checked by a UART receiver model.
module tb_mem_dump_tx;
   localparam int AW = 12;
   localparam int CM = 9;
   localparam int BP = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CM-1:0] halfPeriod = 9'd3;
   logic          start = 1'b0;
   logic [AW-1:0] startAddr = '0;
   logic [AW:0]   wordCount = '0;
   logic [AW-1:0] memAddr;
   logic          memEn;
   logic [31:0]   memData;
   logic          TX, busy, done;

   logic [31:0]   mem [0:4095];
   logic [7:0]    exp_bytes [$];
   logic [AW-1:0] exp_addr [$];
   int            total = 0, bad = 0;
   int            cyc = 0, done_cnt = 0;
   bit            sb_on = 1'b1;

   mem_dump_tx #(.ADDR_WIDTH(AW), .COUNTER_MSB(CM)) dut (
      .clk(clk), .rst_n(rst_n), .halfPeriod(halfPeriod), .start(start),
      .startAddr(startAddr), .wordCount(wordCount), .memAddr(memAddr),
      .memEn(memEn), .memData(memData), .TX(TX), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (memEn) memData <= mem[memAddr];
   always @(negedge clk) if (done === 1'b1) done_cnt++;

   // Read-address scoreboard.
   always @(negedge clk) begin
      if (sb_on && memEn === 1'b1) begin
         total++;
         if (exp_addr.size() == 0) begin
            bad++;
            $display("FAIL mem_read unexpected addr=%h", memAddr);
         end else if (memAddr !== exp_addr[0]) begin
            bad++;
            $display("FAIL mem_read got=%h exp=%h", memAddr, exp_addr[0]);
            void'(exp_addr.pop_front());
         end else begin
            void'(exp_addr.pop_front());
         end
      end
   end

   // UART receiver: sample mid-bit, compare each finished frame against the queue.
   initial begin
      logic [7:0] b;
      logic       sbit, pbit;
      forever begin
         @(negedge clk);
         if (TX === 1'b0) begin
            repeat (BP / 2) @(negedge clk);
            sbit = TX;
            for (int i = 0; i < 8; i++) begin
               repeat (BP) @(negedge clk);
               b[i] = TX;
            end
            repeat (BP) @(negedge clk);
            pbit = TX;
            if (sb_on) begin
               total++;
               if (exp_bytes.size() == 0) begin
                  bad++;
                  $display("FAIL tx_byte unexpected got=%h", b);
               end else if (b !== exp_bytes[0] || sbit !== 1'b0 || pbit !== 1'b1) begin
                  bad++;
                  $display("FAIL tx_byte got=%h start=%b stop=%b exp=%h start=0 stop=1",
                           b, sbit, pbit, exp_bytes[0]);
                  void'(exp_bytes.pop_front());
               end else begin
                  void'(exp_bytes.pop_front());
               end
            end
         end
      end
   end

   function automatic int exp_lat(input int n);
`ifdef DUMP_CHECKSUM_EN
      return n * (40 * BP + 2) + 10 * BP + 1;
`else
      return n * (40 * BP + 2) + 1;
`endif
   endfunction

   task automatic push_exp(input logic [AW-1:0] a, input int n);
      logic [AW-1:0] ad;
      logic [31:0]   w;
      logic [7:0]    cs;
      ad = a;
      cs = 8'h00;
      for (int i = 0; i < n; i++) begin
         exp_addr.push_back(ad);
         w = mem[ad];
         for (int k = 0; k < 4; k++) begin
            exp_bytes.push_back(w[k*8 +: 8]);
            cs = cs ^ w[k*8 +: 8];
         end
         ad = ad + 1'b1;
      end
`ifdef DUMP_CHECKSUM_EN
      exp_bytes.push_back(cs);
`endif
   endtask

   // Queue expectations, pulse start, wait (bounded) for done; lat = -1 on timeout.
   task automatic launch(input logic [AW-1:0] a, input int n, output int lat);
      int s;
      push_exp(a, n);
      @(negedge clk);
      startAddr = a;
      wordCount = n[AW:0];
      start = 1'b1;
      s = cyc;
      lat = -1;
      for (int k = 0; k < 20000; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (done === 1'b1) begin
            lat = cyc - s;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (TX !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || memEn !== 1'b0 || memAddr !== '0) begin
         bad++;
         $display("FAIL reset_state tx=%b busy=%b done=%b en=%b addr=%h exp 1 0 0 0 000",
                  TX, busy, done, memEn, memAddr);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         total++;
         if (TX !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || memEn !== 1'b0) begin
            bad++;
            $display("FAIL idle_quiet cyc=%0d tx=%b busy=%b done=%b en=%b exp 1 0 0 0",
                     i, TX, busy, done, memEn);
         end
      end
   endtask

   task automatic test_single;
      int lat, d0;
      mem[12'h010] = 32'h12345678;
      d0 = done_cnt;
      launch(12'h010, 1, lat);
      repeat (20) @(negedge clk);
      total++;
      if (lat !== exp_lat(1)) begin
         bad++;
         $display("FAIL single_latency got=%0d exp=%0d", lat, exp_lat(1));
      end
      total++;
      if (done_cnt - d0 !== 1 || exp_bytes.size() !== 0 || exp_addr.size() !== 0) begin
         bad++;
         $display("FAIL single_drain dones=%0d bytes_left=%0d reads_left=%0d exp 1 0 0",
                  done_cnt - d0, exp_bytes.size(), exp_addr.size());
      end
   endtask

   task automatic test_wrap;
      int lat, d0;
      d0 = done_cnt;
      launch(12'hFFF, 3, lat);
      repeat (20) @(negedge clk);
      total++;
      if (lat !== exp_lat(3)) begin
         bad++;
         $display("FAIL wrap_latency got=%0d exp=%0d", lat, exp_lat(3));
      end
      total++;
      if (done_cnt - d0 !== 1 || exp_bytes.size() !== 0 || exp_addr.size() !== 0) begin
         bad++;
         $display("FAIL wrap_drain dones=%0d bytes_left=%0d reads_left=%0d exp 1 0 0",
                  done_cnt - d0, exp_bytes.size(), exp_addr.size());
      end
   endtask

   task automatic test_zero;
      int lat, d0;
      d0 = done_cnt;
      launch(12'h123, 0, lat);
      repeat (20) @(negedge clk);
      total++;
      if (lat !== exp_lat(0)) begin
         bad++;
         $display("FAIL zero_latency got=%0d exp=%0d", lat, exp_lat(0));
      end
      total++;
      if (done_cnt - d0 !== 1 || exp_bytes.size() !== 0 || TX !== 1'b1) begin
         bad++;
         $display("FAIL zero_drain dones=%0d bytes_left=%0d tx=%b exp 1 0 1",
                  done_cnt - d0, exp_bytes.size(), TX);
      end
   endtask

   task automatic test_back_to_back;
      int s, lat, d0;
      push_exp(12'h100, 2);
      d0 = done_cnt;
      @(negedge clk);
      startAddr = 12'h100; wordCount = 13'd2; start = 1'b1; s = cyc;
      @(negedge clk); start = 1'b0;
      repeat (100) @(negedge clk);
      startAddr = 12'h555; wordCount = 13'd5; start = 1'b1;
      @(negedge clk); start = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL busy_mid_dump got=%b exp=1", busy);
      end
      repeat (300) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      lat = -1;
      for (int k = 0; k < 5000; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = cyc - s;
            startAddr = 12'h200; wordCount = 13'd1; start = 1'b1;
            break;
         end
      end
      @(negedge clk); start = 1'b0;
      repeat (100) @(negedge clk);
      total++;
      if (lat !== exp_lat(2)) begin
         bad++;
         $display("FAIL ignore_latency got=%0d exp=%0d", lat, exp_lat(2));
      end
      total++;
      if (done_cnt - d0 !== 1 || exp_bytes.size() !== 0 || exp_addr.size() !== 0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL ignore_drain dones=%0d bytes_left=%0d reads_left=%0d busy=%b exp 1 0 0 0",
                  done_cnt - d0, exp_bytes.size(), exp_addr.size(), busy);
      end
   endtask

   task automatic test_reset_mid;
      int lat, d0;
      sb_on = 1'b0;
      @(negedge clk);
      startAddr = 12'h020; wordCount = 13'd1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (182) @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if (TX !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || memEn !== 1'b0) begin
         bad++;
         $display("FAIL midreset_state tx=%b busy=%b done=%b en=%b exp 1 0 0 0", TX, busy, done, memEn);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (120) @(negedge clk);
      total++;
      if (TX !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL midreset_idle tx=%b busy=%b exp 1 0", TX, busy);
      end
      exp_bytes.delete();
      exp_addr.delete();
      sb_on = 1'b1;
      d0 = done_cnt;
      launch(12'h7F0, 2, lat);
      repeat (20) @(negedge clk);
      total++;
      if (lat !== exp_lat(2)) begin
         bad++;
         $display("FAIL post_reset_latency got=%0d exp=%0d", lat, exp_lat(2));
      end
      total++;
      if (done_cnt - d0 !== 1 || exp_bytes.size() !== 0 || exp_addr.size() !== 0) begin
         bad++;
         $display("FAIL post_reset_drain dones=%0d bytes_left=%0d reads_left=%0d exp 1 0 0",
                  done_cnt - d0, exp_bytes.size(), exp_addr.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = $urandom;
      test_reset;
      test_single;
      test_wrap;
      test_zero;
      test_back_to_back;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_dump_tx.md
Name: mem_dump_tx

Overview:
- Readback engine, the transmit-side counterpart of the UART reprogramming path into the boot RAM.
- On a start pulse, reads a block of 32-bit words from a synchronous-read memory port and serialises them over UART 8N1.
- Byte order is least-significant byte first, the same byte stream the programming receiver consumes.
- Sits on the memory's B-side clock domain and connects directly to a board TX pin.

Parameters:
ADDR_WIDTH, 12, word-address width of the memory port.
COUNTER_MSB, 9, width of halfPeriod; baud counter is COUNTER_MSB+1 bits.

Ports:
clk  input  1  the single clock; all logic on its rising edge.
rst_n  input  1  asynchronous active-low reset.
halfPeriod  input  COUNTER_MSB  half bit time; bit period = 2*(halfPeriod+1) clk cycles (433 -> 868).
start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
startAddr  input  ADDR_WIDTH  first word address, latched on accepted start.
wordCount  input  ADDR_WIDTH+1  number of words to send, 0..2^ADDR_WIDTH; latched on accepted start.
memAddr  output  ADDR_WIDTH  read address to memory.
memEn  output  1  read enable; data valid on memData the cycle after memEn is high.
memData  input  32  read data.
TX  output  1  UART line, idle high.
busy  output  1  high from the cycle after an accepted start until DONE.
done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (async, rst_n low): state IDLE, TX=1, busy=0, done=0, memEn=0, memAddr=0, all counters 0.
  - Reset mid-frame aborts immediately; TX returns high in the same reset assertion, and no partial byte is resumed.
- IDLE:
  - start=1 latches startAddr into the address counter and wordCount into the remaining counter.
  - If wordCount=0, go to DONE; otherwise go to FETCH.
  - start while not in IDLE is ignored and not queued.
- FETCH (1 cycle): memEn=1, memAddr=current address; go to LATCH.
- LATCH (1 cycle): capture memData into a 32-bit shift word; byte index=0; go to SEND.
- SEND, per byte, bit timer reloaded at each bit boundary:
  - Start bit: TX=0 for one bit period.
  - Data bits 0..7, LSB first, one bit period each.
  - Stop bit: TX=1 for one bit period.
  - No idle gap between consecutive bytes of the same word.
- After the stop bit of byte 3:
  - Decrement remaining and increment address; address wraps modulo 2^ADDR_WIDTH.
  - If remaining becomes 0, go to DONE; otherwise go to FETCH.
  - TX stays high during FETCH/LATCH, giving 2 extra idle cycles between words.
- DONE (1 cycle): done=1, busy drops to 0; next state IDLE. A start in the DONE cycle is ignored.
- memEn is high only in FETCH. memAddr holds its last value at all other times.
- Timing:
  - Total clk cycles from accepted start to done pulse = N*(40*bitPeriod+2)+1 for N>0.
  - For N=0, done asserts 1 cycle after start.
- halfPeriod must be held stable while busy; changing it mid-dump is undefined.

Optional Feature:
- Macro DUMP_CHECKSUM_EN.
- When defined:
  - After the last word, one extra byte is sent: the XOR of every transmitted data byte.
  - For wordCount=0 the checksum byte is 0x00 and is still sent.
  - DONE follows the checksum's stop bit.
  - Checksum register clears on each accepted start.
- When undefined:
  - No checksum logic or state exists.
  - DONE follows the last word's byte 3.

Test Plan:
- Reset with rst_n=0 then release, no start -> TX=1, busy=0, done=0, memEn=0 indefinitely.
- halfPeriod=3 (bit period 8), startAddr=0x010, wordCount=1, memory[0x010]=0x12345678:
  - memEn pulses once with memAddr=0x010.
  - TX frames bytes 0x78,0x56,0x34,0x12, each start low 8 cycles, LSB first, stop high.
  - done pulses once, 323 cycles after start.
- wordCount=3, startAddr=0xFFF:
  - Reads addresses 0xFFF, 0x000, 0x001 in order (wrap).
  - 12 bytes sent, then exactly one done pulse.
- wordCount=0 -> no memEn, TX stays high, done pulses the cycle after start (checksum variant: one 0x00 byte first).
- start re-asserted while busy, and in the DONE cycle -> ignored; byte stream and done count unchanged.
- Reset asserted mid-data-bit of byte 2 -> TX=1 immediately, state IDLE; a new start after release runs a full, correct dump.
